// File: rtl/cascade_rom_arbiter_if.sv
// Request/grant/read-return bundle between the two requesters, the arbiter and the cascade ROM.
// The slave modport is the arbiter's view. The master modport is the requester/ROM side.
interface cascade_rom_arbiter_if #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DATA_W = 32
);
   logic              a_req;
   logic [ADDR_W-1:0] a_addr;
   logic              a_gnt;
   logic              a_rvalid;
   logic [DATA_W-1:0] a_rdata;
   logic              b_req;
   logic [ADDR_W-1:0] b_addr;
   logic              b_last;
   logic              b_gnt;
   logic              b_rvalid;
   logic [DATA_W-1:0] b_rdata;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              busy;

   modport slave (
      input  a_req, a_addr, b_req, b_addr, b_last, rom_data,
      output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, rom_en, rom_addr, busy
   );

   modport master (
      output a_req, a_addr, b_req, b_addr, b_last, rom_data,
      input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, rom_en, rom_addr, busy
   );
endinterface

// File: rtl/cascade_rom_arbiter.sv
// Round-robin arbiter for the single-port cascade ROM. It supports a bounded B burst lock and
// returns each read through a fixed-latency owner-tag pipeline.
module cascade_rom_arbiter #(
   parameter int unsigned ADDR_W      = 14,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ROM_LATENCY = 1,
   parameter int unsigned MAX_BURST   = 4
) (
   input logic                  clk,
   input logic                  rst,
   cascade_rom_arbiter_if.slave bus_io
);
   localparam int unsigned CntW = $clog2(MAX_BURST + 1);
   localparam int unsigned Last = ROM_LATENCY - 1;

   typedef enum logic {StArb, StLockB} state_e;

   state_e                 state_q, state_d;
   logic                   last_winner_q, last_winner_d;
   logic [CntW-1:0]        burst_cnt_q, burst_cnt_d;
   logic [ROM_LATENCY-1:0] tag_valid_q;
   logic [ROM_LATENCY-1:0] tag_owner_q;
   logic                   a_gnt, b_gnt;

   always_comb begin
      state_d       = state_q;
      last_winner_d = last_winner_q;
      burst_cnt_d   = burst_cnt_q;
      a_gnt         = 1'b0;
      b_gnt         = 1'b0;
      unique case (state_q)
         StArb: begin
            if (bus_io.a_req && bus_io.b_req) begin
               a_gnt = last_winner_q;
               b_gnt = ~last_winner_q;
            end else begin
               a_gnt = bus_io.a_req;
               b_gnt = bus_io.b_req;
            end
            // A single-beat cap means a first unlocked beat is already a forced release.
            if (b_gnt && !bus_io.b_last && (MAX_BURST > 1)) begin
               state_d     = StLockB;
               burst_cnt_d = CntW'(1);
            end
         end
         StLockB: begin
            b_gnt = bus_io.b_req;
            if (b_gnt) begin
               burst_cnt_d = burst_cnt_q + 1'b1;
               if (bus_io.b_last || (burst_cnt_d == CntW'(MAX_BURST))) begin
                  state_d     = StArb;
                  burst_cnt_d = '0;
               end
            end
         end
         default: state_d = StArb;
      endcase
      if (a_gnt) last_winner_d = 1'b0;
      if (b_gnt) last_winner_d = 1'b1;
      if (rst) begin
         a_gnt = 1'b0;
         b_gnt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StArb;
         last_winner_q <= 1'b1;
         burst_cnt_q   <= '0;
         tag_valid_q   <= '0;
         tag_owner_q   <= '0;
      end else begin
         state_q        <= state_d;
         last_winner_q  <= last_winner_d;
         burst_cnt_q    <= burst_cnt_d;
         tag_valid_q[0] <= a_gnt | b_gnt;
         tag_owner_q[0] <= b_gnt;
         for (int i = 1; i < ROM_LATENCY; i++) begin
            tag_valid_q[i] <= tag_valid_q[i-1];
            tag_owner_q[i] <= tag_owner_q[i-1];
         end
      end
   end

   assign bus_io.a_gnt    = a_gnt;
   assign bus_io.b_gnt    = b_gnt;
   assign bus_io.rom_en   = a_gnt | b_gnt;
   assign bus_io.rom_addr = a_gnt ? bus_io.a_addr : (b_gnt ? bus_io.b_addr : '0);

   // Returns still in the pipeline during reset are suppressed immediately.
   assign bus_io.a_rvalid = !rst && tag_valid_q[Last] && !tag_owner_q[Last];
   assign bus_io.b_rvalid = !rst && tag_valid_q[Last] && tag_owner_q[Last];
   assign bus_io.a_rdata  = bus_io.a_rvalid ? bus_io.rom_data : '0;
   assign bus_io.b_rdata  = bus_io.b_rvalid ? bus_io.rom_data : '0;
   assign bus_io.busy     = !rst && ((|tag_valid_q) || (state_q == StLockB));
endmodule

// File: tb/tb_cascade_rom_arbiter.sv
// Directed bench for cascade_rom_arbiter. It drives DUTs at ROM latencies 1 and 3 from one
// stimulus stream, using table rows plus hand-written latency and reset sequences.
module tb_cascade_rom_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   cascade_rom_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus1 ();
   cascade_rom_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus3 ();

   cascade_rom_arbiter #(.ADDR_W(14), .DATA_W(32), .ROM_LATENCY(1), .MAX_BURST(4)) u_dut1 (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus1)
   );

   cascade_rom_arbiter #(.ADDR_W(14), .DATA_W(32), .ROM_LATENCY(3), .MAX_BURST(4)) u_dut3 (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus3)
   );

   assign bus3.a_req  = bus1.a_req;
   assign bus3.a_addr = bus1.a_addr;
   assign bus3.b_req  = bus1.b_req;
   assign bus3.b_addr = bus1.b_addr;
   assign bus3.b_last = bus1.b_last;

   function automatic logic [31:0] rom_word(input logic [13:0] a);
      return {a, 4'h5, a};
   endfunction

   logic [31:0] rom1_q;
   logic [31:0] rom3_q [3];
   always @(posedge clk) begin
      rom1_q    <= rom_word(bus1.rom_addr);
      rom3_q[0] <= rom_word(bus3.rom_addr);
      rom3_q[1] <= rom3_q[0];
      rom3_q[2] <= rom3_q[1];
   end
   assign bus1.rom_data = rom1_q;
   assign bus3.rom_data = rom3_q[2];

   typedef struct {
      logic        rst;
      logic        a_req;
      logic [13:0] a_addr;
      logic        b_req;
      logic [13:0] b_addr;
      logic        b_last;
      logic        e_agnt;
      logic        e_bgnt;
      logic [13:0] e_raddr;
      logic        e_arv;
      logic        e_brv;
      logic        e_busy;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic ar, input logic [13:0] aa,
                               input logic br, input logic [13:0] ba, input logic bl,
                               input logic eag, input logic ebg, input logic [13:0] era,
                               input logic earv, input logic ebrv, input logic ebusy);
      vec_t v;
      v.rst = r; v.a_req = ar; v.a_addr = aa; v.b_req = br; v.b_addr = ba; v.b_last = bl;
      v.e_agnt = eag; v.e_bgnt = ebg; v.e_raddr = era;
      v.e_arv = earv; v.e_brv = ebrv; v.e_busy = ebusy;
      return v;
   endfunction

   function automatic logic [83:0] obs1();
      return {bus1.a_gnt, bus1.b_gnt, bus1.rom_en, bus1.rom_addr, bus1.a_rvalid, bus1.b_rvalid,
              bus1.busy, bus1.a_rdata, bus1.b_rdata};
   endfunction

   function automatic logic [83:0] obs3();
      return {bus3.a_gnt, bus3.b_gnt, bus3.rom_en, bus3.rom_addr, bus3.a_rvalid, bus3.b_rvalid,
              bus3.busy, bus3.a_rdata, bus3.b_rdata};
   endfunction

   task automatic check(input string nm, input logic [83:0] act, input logic [83:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, exp_v);
      end
   endtask

   // Drive one cycle just after the edge and compare on the falling edge.
   task automatic run_vec(input string nm, input vec_t v, input logic [13:0] rd_addr,
                          input bit use3);
      logic [31:0] ea, eb;
      @(posedge clk); #1;
      rst         = v.rst;
      bus1.a_req  = v.a_req;
      bus1.a_addr = v.a_addr;
      bus1.b_req  = v.b_req;
      bus1.b_addr = v.b_addr;
      bus1.b_last = v.b_last;
      @(negedge clk);
      ea = v.e_arv ? rom_word(rd_addr) : 32'h0;
      eb = v.e_brv ? rom_word(rd_addr) : 32'h0;
      check(nm, use3 ? obs3() : obs1(),
            {v.e_agnt, v.e_bgnt, v.e_agnt | v.e_bgnt, v.e_raddr, v.e_arv, v.e_brv, v.e_busy,
             ea, eb});
   endtask

   vec_t        tbl[$];
   logic [13:0] prev_raddr;
   logic [13:0] ga [10];

   initial begin
      bus1.a_req = 1'b1; bus1.a_addr = 14'h0AA; bus1.b_req = 1'b1;
      bus1.b_addr = 14'h0BB; bus1.b_last = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs_lat1", obs1(), 84'h0);
      check("reset_outputs_lat3", obs3(), 84'h0);

      // Continuous A/B alternation starting with A.
      tbl.push_back(mk(0, 0, 14'h000, 0, 14'h000, 0, 0, 0, 14'h000, 0, 0, 0));
      tbl.push_back(mk(0, 1, 14'h100, 1, 14'h200, 1, 1, 0, 14'h100, 0, 0, 0));
      tbl.push_back(mk(0, 1, 14'h101, 1, 14'h200, 1, 0, 1, 14'h200, 1, 0, 1));
      tbl.push_back(mk(0, 1, 14'h101, 1, 14'h201, 1, 1, 0, 14'h101, 0, 1, 1));
      tbl.push_back(mk(0, 0, 14'h000, 1, 14'h201, 1, 0, 1, 14'h201, 1, 0, 1));
      tbl.push_back(mk(0, 0, 14'h000, 0, 14'h000, 0, 0, 0, 14'h000, 0, 1, 1));
      tbl.push_back(mk(0, 0, 14'h000, 0, 14'h000, 0, 0, 0, 14'h000, 0, 0, 0));
      // Single A read.
      tbl.push_back(mk(0, 1, 14'h010, 0, 14'h000, 0, 1, 0, 14'h010, 0, 0, 0));
      tbl.push_back(mk(0, 0, 14'h000, 0, 14'h000, 0, 0, 0, 14'h000, 1, 0, 1));
      // B burst 0,0,0,1 against a waiting A.
      tbl.push_back(mk(0, 1, 14'h300, 1, 14'h400, 0, 0, 1, 14'h400, 0, 0, 0));
      tbl.push_back(mk(0, 1, 14'h300, 1, 14'h401, 0, 0, 1, 14'h401, 0, 1, 1));
      tbl.push_back(mk(0, 1, 14'h300, 1, 14'h402, 0, 0, 1, 14'h402, 0, 1, 1));
      tbl.push_back(mk(0, 1, 14'h300, 1, 14'h403, 1, 0, 1, 14'h403, 0, 1, 1));
      tbl.push_back(mk(0, 1, 14'h300, 0, 14'h000, 0, 1, 0, 14'h300, 0, 1, 1));
      tbl.push_back(mk(0, 0, 14'h000, 0, 14'h000, 0, 0, 0, 14'h000, 1, 0, 1));
      tbl.push_back(mk(0, 0, 14'h000, 0, 14'h000, 0, 0, 0, 14'h000, 0, 0, 0));
      // Forced release after four locked beats, then B relocks.
      tbl.push_back(mk(0, 1, 14'h500, 1, 14'h600, 0, 0, 1, 14'h600, 0, 0, 0));
      tbl.push_back(mk(0, 1, 14'h500, 1, 14'h601, 0, 0, 1, 14'h601, 0, 1, 1));
      tbl.push_back(mk(0, 1, 14'h500, 1, 14'h602, 0, 0, 1, 14'h602, 0, 1, 1));
      tbl.push_back(mk(0, 1, 14'h500, 1, 14'h603, 0, 0, 1, 14'h603, 0, 1, 1));
      tbl.push_back(mk(0, 1, 14'h500, 1, 14'h604, 0, 1, 0, 14'h500, 0, 1, 1));
      tbl.push_back(mk(0, 0, 14'h000, 1, 14'h604, 0, 0, 1, 14'h604, 1, 0, 1));
      tbl.push_back(mk(0, 0, 14'h000, 1, 14'h605, 0, 0, 1, 14'h605, 0, 1, 1));
      tbl.push_back(mk(0, 0, 14'h000, 1, 14'h606, 1, 0, 1, 14'h606, 0, 1, 1));
      tbl.push_back(mk(0, 0, 14'h000, 0, 14'h000, 0, 0, 0, 14'h000, 0, 1, 1));
      tbl.push_back(mk(0, 0, 14'h000, 0, 14'h000, 0, 0, 0, 14'h000, 0, 0, 0));
      // b_req drops while locked: the lock holds and A stays blocked.
      tbl.push_back(mk(0, 0, 14'h000, 1, 14'h700, 0, 0, 1, 14'h700, 0, 0, 0));
      tbl.push_back(mk(0, 1, 14'h710, 0, 14'h000, 0, 0, 0, 14'h000, 0, 1, 1));
      tbl.push_back(mk(0, 1, 14'h710, 1, 14'h701, 1, 0, 1, 14'h701, 0, 0, 1));
      tbl.push_back(mk(0, 1, 14'h710, 0, 14'h000, 0, 1, 0, 14'h710, 0, 1, 1));
      tbl.push_back(mk(0, 0, 14'h000, 0, 14'h000, 0, 0, 0, 14'h000, 1, 0, 1));
      tbl.push_back(mk(0, 0, 14'h000, 0, 14'h000, 0, 0, 0, 14'h000, 0, 0, 0));

      prev_raddr = 14'h0;
      foreach (tbl[i]) begin
         run_vec($sformatf("row%0d", i), tbl[i], prev_raddr, 1'b0);
         prev_raddr = tbl[i].e_raddr;
      end

      // Latency 3: alternating grants return exactly three cycles later.
      run_vec("l3_reset", mk(1, 0, 14'h000, 0, 14'h000, 0, 0, 0, 14'h000, 0, 0, 0), 14'h0, 1'b1);
      ga = '{14'h1000, 14'h2000, 14'h1001, 14'h2001, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0};
      for (int c = 0; c < 10; c++) begin
         run_vec($sformatf("lat3_c%0d", c),
                 mk(0, c <= 2, (c == 0) ? 14'h1000 : 14'h1001,
                    c <= 3, (c <= 1) ? 14'h2000 : 14'h2001, 1,
                    (c == 0) || (c == 2), (c == 1) || (c == 3), ga[c],
                    (c == 3) || (c == 5), (c == 4) || (c == 6), (c >= 1) && (c <= 6)),
                 (c >= 3) ? ga[c-3] : 14'h0, 1'b1);
      end

      // Reset with two reads in flight, leaving last_winner at A beforehand.
      run_vec("rst_c0", mk(0, 0, 14'h000, 1, 14'h2100, 1, 0, 1, 14'h2100, 0, 0, 0), 14'h0, 1'b1);
      run_vec("rst_c1", mk(0, 1, 14'h1100, 0, 14'h000, 0, 1, 0, 14'h1100, 0, 0, 1), 14'h0, 1'b1);
      run_vec("rst_c2_lat3", mk(1, 1, 14'h1200, 1, 14'h2200, 1, 0, 0, 14'h0, 0, 0, 0),
              14'h0, 1'b1);
      check("rst_c2_lat1", obs1(), 84'h0);
      run_vec("rst_c3", mk(0, 1, 14'h1200, 1, 14'h2200, 1, 1, 0, 14'h1200, 0, 0, 0),
              14'h0, 1'b1);
      run_vec("rst_c4", mk(0, 0, 14'h000, 1, 14'h2200, 1, 0, 1, 14'h2200, 0, 0, 1),
              14'h0, 1'b1);
      run_vec("rst_c5", mk(0, 0, 14'h000, 0, 14'h000, 0, 0, 0, 14'h0, 0, 0, 1), 14'h0, 1'b1);
      run_vec("rst_c6", mk(0, 0, 14'h000, 0, 14'h000, 0, 0, 0, 14'h0, 1, 0, 1), 14'h1200, 1'b1);
      run_vec("rst_c7", mk(0, 0, 14'h000, 0, 14'h000, 0, 0, 0, 14'h0, 0, 1, 1), 14'h2200, 1'b1);
      run_vec("rst_c8", mk(0, 0, 14'h000, 0, 14'h000, 0, 0, 0, 14'h0, 0, 0, 0), 14'h0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
